// File: rtl/os2ip_arb_pkg.sv
// Shared types and constants for the OS2IP unit arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package os2ip_arb_pkg;

  // Arbiter FSM: one operation in flight, no pipelining.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Default operand/result width (RSA-2048 modulus).
  localparam int RSA_WIDTH = 2048;

  // Grant-index width; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/os2ip_arbiter_if.sv
// Requester and OS2IP-unit signals shared by the arbiter and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req_valid until the one-cycle req_ready strobe.
interface os2ip_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 2048
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_X;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]         resp_x;
  logic                     resp_err;
  logic                     busy;
  logic                     unit_valid;
  logic [WIDTH-1:0]         unit_X;
  logic                     unit_o_valid;
  logic [WIDTH-1:0]         unit_x;

  // Arbiter side.
  modport slave (
    input  req_valid, req_X, unit_o_valid, unit_x,
    output req_ready, resp_valid, resp_x, resp_err, busy, unit_valid, unit_X
  );

  // Requesters plus the OS2IP unit.
  modport master (
    output req_valid, req_X, unit_o_valid, unit_x,
    input  req_ready, resp_valid, resp_x, resp_err, busy, unit_valid, unit_X
  );

endinterface

// File: rtl/os2ip_rr_pick.sv
// Round-robin picker: first requesting index searching upward from ptr_i+1.
// Latency: purely combinational.
// Backpressure: none; any_o=0 when no request is present.
module os2ip_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Walk the ring once starting just after the last winner; first hit wins.
  always_comb begin
    int cand;
    cand  = 0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[IDX_W'(cand)]) begin
        idx_o = IDX_W'(cand);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/os2ip_arbiter.sv
// Shares one OS2IP conversion unit between NUM_REQ requesters, round-robin, with a watchdog.
// Latency: accept at N, unit launch at N+1, response one cycle after unit done (or timeout).
// Backpressure: one op in flight; requesters hold req_valid until req_ready, no queueing inside.
module os2ip_arbiter
  import os2ip_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = RSA_WIDTH,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  os2ip_arbiter_if.slave   bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             timeout_hit;

  os2ip_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and datapath update; unit done beats the watchdog in the same cycle.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    res_d    = res_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          op_d    = bus.req_X[int'(pick_idx)*WIDTH +: WIDTH];
          gnt_d   = pick_idx;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.unit_o_valid) begin
          res_d   = bus.unit_x;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timeout_hit) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        rr_ptr_d = gnt_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      gnt_q    <= '0;
      op_q     <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      res_q    <= res_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Strobes decoded from state; accept strobe is forced low while reset is held.
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.resp_x     = '0;
    bus.resp_err   = 1'b0;
    bus.busy       = (state_q != IDLE);
    bus.unit_valid = (state_q == LAUNCH);
    bus.unit_X     = op_q;
    if (reset && state_q == IDLE && pick_any) begin
      bus.req_ready[pick_idx] = 1'b1;
    end
    if (state_q == RESP) begin
      bus.resp_valid[gnt_q] = 1'b1;
      bus.resp_x            = res_q;
      bus.resp_err          = err_q;
    end
  end

endmodule

// File: tb/tb_os2ip_arbiter.sv
// Scoreboard bench for os2ip_arbiter: random requesters, random unit latency, spurious done strobes.
// Latency: reference model predicts accept cycle, launch cycle and response cycle of every op.
// Backpressure: requesters hold req_valid until their predicted accept, then may re-request.
module tb_os2ip_arbiter;

  localparam int NR = 2;
  localparam int W  = 64;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  os2ip_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

  os2ip_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    int           g;
    logic [W-1:0] x;
    logic         err;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model state (owned by the monitor).
  int           last_g  = NR - 1;
  int           g_cyc   = -100;
  int           r_cyc   = -100;
  int           ov_cyc  = -1;
  logic [W-1:0] ov_val  = '0;
  logic [W-1:0] op_model = '0;
  int           gnt_at[NR];
  logic         fin_done = 1'b0;

  // Stimulus controls (owned by the main process).
  logic          rst_drive = 1'b0;
  logic [NR-1:0] en        = '0;
  logic [NR-1:0] pend      = '0;
  logic [W-1:0]  opnd[NR];
  int            pct       = 0;
  int            spur      = 0;
  int            l_fixed   = 0;
  logic          fixed_op  = 1'b0;
  logic          final_chk = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // One clock of stimulus: requester holds/re-requests, unit done strobe (scheduled or spurious).
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    reset = rst_drive;
    for (int i = 0; i < NR; i++) begin
      if (!rst_drive) begin
        pend[1'(i)] = 1'b0;
      end else begin
        if (pend[1'(i)] && gnt_at[1'(i)] == cyc - 1) pend[1'(i)] = 1'b0;
        if (!pend[1'(i)] && en[1'(i)] && $urandom_range(0, 99) < pct) begin
          pend[1'(i)] = 1'b1;
          opnd[1'(i)] = fixed_op ? 64'h030201 : {$urandom, $urandom};
        end
      end
      bus.req_X[i*W +: W] = opnd[1'(i)];
    end
    bus.req_valid = pend;
    if (rst_drive && cyc == ov_cyc) begin
      bus.unit_o_valid = 1'b1;
      bus.unit_x       = ov_val;
    end else if (rst_drive && !(cyc >= g_cyc + 2 && cyc < r_cyc) && $urandom_range(0, 99) < spur) begin
      bus.unit_o_valid = 1'b1;
      bus.unit_x       = {$urandom, $urandom};
    end else begin
      bus.unit_o_valid = 1'b0;
      bus.unit_x       = {$urandom, $urandom};
    end
  endtask

  task automatic drain();
    en = '0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (expq.size() == 0 && pend == '0 && cyc > r_cyc) break;
    end
  endtask

  // Monitor: predicts grants from the round-robin rule and checks every output each cycle.
  always @(negedge clk) begin : mon
    exp_t          e;
    logic [NR-1:0] exp_rdy;
    int            g;
    int            c;
    int            lat;
    exp_rdy = '0;
    g       = -1;
    c       = 0;
    lat     = 0;
    if (!reset) begin
      chk("rst_req_ready",  64'(bus.req_ready),  64'(0));
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
      chk("rst_resp_x",     64'(bus.resp_x),     64'(0));
      chk("rst_resp_err",   64'(bus.resp_err),   64'(0));
      chk("rst_busy",       64'(bus.busy),       64'(0));
      chk("rst_unit_valid", 64'(bus.unit_valid), 64'(0));
      chk("rst_unit_X",     64'(bus.unit_X),     64'(0));
      last_g   = NR - 1;
      g_cyc    = -100;
      r_cyc    = -100;
      ov_cyc   = -1;
      op_model = '0;
      expq.delete();
      for (int i = 0; i < NR; i++) gnt_at[1'(i)] = -10;
    end else begin
      chk("busy",       64'(bus.busy),       64'(cyc > g_cyc && cyc <= r_cyc));
      chk("unit_valid", 64'(bus.unit_valid), 64'(cyc == g_cyc + 1));
      chk("unit_X",     64'(bus.unit_X),     64'(op_model));
      if (bus.resp_valid != '0) begin
        if (expq.size() == 0) begin
          chk("resp_unexpected", 64'(bus.resp_valid), 64'(0));
        end else begin
          e = expq.pop_front();
          chk("resp_cycle", 64'(cyc),            64'(e.cyc));
          chk("resp_valid", 64'(bus.resp_valid), 64'(1) << e.g);
          chk("resp_x",     64'(bus.resp_x),     64'(e.x));
          chk("resp_err",   64'(bus.resp_err),   64'(e.err));
        end
      end else begin
        chk("resp_x_quiet",   64'(bus.resp_x),   64'(0));
        chk("resp_err_quiet", 64'(bus.resp_err), 64'(0));
        if (expq.size() > 0 && expq[0].cyc <= cyc) begin
          chk("resp_missing", 64'(bus.resp_valid), 64'(1) << expq[0].g);
          void'(expq.pop_front());
        end
      end
      // Grant prediction: arbiter is free the cycle after its last response.
      if (r_cyc < cyc && bus.req_valid != '0) begin
        for (int k = 1; k <= NR; k++) begin
          c = (last_g + k) % NR;
          if (g < 0 && ((bus.req_valid >> c) & 1) != 0) g = c;
        end
        exp_rdy = NR'(1) << g;
        lat     = (l_fixed > 0) ? l_fixed : int'($urandom_range(1, 20));
        g_cyc   = cyc;
        e.g     = g;
        if (lat <= TO) begin
          r_cyc  = cyc + 2 + lat;
          ov_cyc = cyc + 1 + lat;
          ov_val = opnd[1'(g)];
          e.x    = opnd[1'(g)];
          e.err  = 1'b0;
        end else begin
          r_cyc  = cyc + 2 + TO;
          ov_cyc = -1;
          e.x    = '0;
          e.err  = 1'b1;
        end
        e.cyc = r_cyc;
        expq.push_back(e);
        op_model       = opnd[1'(g)];
        last_g         = g;
        gnt_at[1'(g)]  = cyc;
      end
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    end
    if (final_chk && !fin_done) begin
      chk("queue_empty", 64'(expq.size()), 64'(0));
      chk("idle_at_end", 64'(bus.busy),    64'(0));
      fin_done = 1'b1;
    end
  end

  initial begin
    opnd[0]          = '0;
    opnd[1]          = '0;
    bus.req_valid    = '0;
    bus.req_X        = '0;
    bus.unit_o_valid = 1'b0;
    bus.unit_x       = '0;

    // Reset state.
    rst_drive = 1'b0;
    repeat (3) step();

    // Single request, unit latency 5, identity conversion of 'h030201.
    rst_drive = 1'b1;
    step();
    l_fixed  = 5;
    fixed_op = 1'b1;
    en       = 2'b01;
    pct      = 100;
    step();
    en       = '0;
    fixed_op = 1'b0;
    drain();

    // Both requesting at reset release; search starts at rr_ptr+1 so grants alternate.
    rst_drive = 1'b0;
    repeat (2) step();
    en        = 2'b11;
    rst_drive = 1'b1;
    repeat (40) step();
    drain();

    // Done on the expiry cycle, then a true timeout, then a normal op; spurious strobes outside WAIT.
    spur    = 20;
    l_fixed = TO;
    en      = 2'b01;
    step();
    drain();
    l_fixed = 30;
    en      = 2'b10;
    step();
    drain();
    l_fixed = 5;
    en      = 2'b01;
    step();
    drain();

    // Random traffic with random unit latency (including expiry-cycle and timeout cases).
    l_fixed = 0;
    pct     = 30;
    spur    = 15;
    en      = 2'b11;
    repeat (1500) step();
    drain();

    // Reset while waiting on the unit: op is dropped, then requester 1 is served normally.
    spur    = 0;
    l_fixed = 10;
    pct     = 100;
    en      = 2'b01;
    step();
    en = '0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (cyc >= g_cyc + 2 && cyc < r_cyc - 2) break;
    end
    rst_drive = 1'b0;
    repeat (3) step();
    rst_drive = 1'b1;
    l_fixed   = 5;
    en        = 2'b10;
    step();
    drain();

    final_chk = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (fin_done) break;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
